// File: rtl/time_digit_editor_if.sv
// ---------------------------------------------------------------------------
// time_digit_editor_if
//
// Purpose: bundles the control inputs and BCD time outputs of
// time_digit_editor so the sequencer/debouncer side and the display side
// can share one connection.
//
// Signals:
//   SEL_MODE0           1 = set mode, 0 = run mode
//   CURRENT_STATE_TIME  7-bit one-hot digit select from the set-time sequencer
//   EN_1HZ              one-CLK-wide pulse, once per second
//   BAP_BTN3            one-CLK-wide debounced "up" pulse
//   BAP_BTN4            one-CLK-wide debounced "down" pulse (TIME_SET_DOWN_EN only)
//   TIME_H10..TIME_S1   BCD time digits HH:MM:SS
//   DAY_CARRY           one-cycle pulse on the 23:59:59 -> 00:00:00 rollover
//
// Modports:
//   master  drives the controls, observes the time (sequencer / testbench)
//   slave   the time_digit_editor itself
//
// Configuration macro: TIME_SET_DOWN_EN adds BAP_BTN4.
// ---------------------------------------------------------------------------
interface time_digit_editor_if;
    logic       SEL_MODE0;
    logic [6:0] CURRENT_STATE_TIME;
    logic       EN_1HZ;
    logic       BAP_BTN3;
`ifdef TIME_SET_DOWN_EN
    logic       BAP_BTN4;
`endif
    logic [1:0] TIME_H10;
    logic [3:0] TIME_H1;
    logic [2:0] TIME_M10;
    logic [3:0] TIME_M1;
    logic [2:0] TIME_S10;
    logic [3:0] TIME_S1;
    logic       DAY_CARRY;

`ifdef TIME_SET_DOWN_EN
    modport master (
        output SEL_MODE0, CURRENT_STATE_TIME, EN_1HZ, BAP_BTN3, BAP_BTN4,
        input  TIME_H10, TIME_H1, TIME_M10, TIME_M1, TIME_S10, TIME_S1, DAY_CARRY
    );
    modport slave (
        input  SEL_MODE0, CURRENT_STATE_TIME, EN_1HZ, BAP_BTN3, BAP_BTN4,
        output TIME_H10, TIME_H1, TIME_M10, TIME_M1, TIME_S10, TIME_S1, DAY_CARRY
    );
`else
    modport master (
        output SEL_MODE0, CURRENT_STATE_TIME, EN_1HZ, BAP_BTN3,
        input  TIME_H10, TIME_H1, TIME_M10, TIME_M1, TIME_S10, TIME_S1, DAY_CARRY
    );
    modport slave (
        input  SEL_MODE0, CURRENT_STATE_TIME, EN_1HZ, BAP_BTN3,
        output TIME_H10, TIME_H1, TIME_M10, TIME_M1, TIME_S10, TIME_S1, DAY_CARRY
    );
`endif
endinterface

// File: rtl/time_digit_editor.sv
// ---------------------------------------------------------------------------
// time_digit_editor
//
// Purpose: holds a 24-hour BCD time HH:MM:SS. In run mode the time advances
// once per EN_1HZ with full carry propagation; in set mode each button pulse
// steps only the digit chosen by CURRENT_STATE_TIME, with no carry into the
// neighbouring digits. All outputs are registered.
//
// Ports:
//   CLK    system clock, all state changes on posedge
//   RESET  asynchronous, active-high reset (loads RST_HOUR:RST_MIN:RST_SEC)
//   tbus   time_digit_editor_if.slave: controls in, BCD digits + DAY_CARRY out
//
// Parameters:
//   RST_HOUR (0..23), RST_MIN (0..59), RST_SEC (0..59): reset time.
//
// Configuration macro: TIME_SET_DOWN_EN enables BAP_BTN4 as a "down" button
// in set mode; pressing up and down together changes nothing.
// ---------------------------------------------------------------------------
module time_digit_editor #(
    parameter int RST_HOUR = 0,
    parameter int RST_MIN  = 0,
    parameter int RST_SEC  = 0
) (
    input  logic                      CLK,
    input  logic                      RESET,
    time_digit_editor_if.slave        tbus
);

    typedef enum logic [6:0] {
        SEL_BASE   = 7'b0000001,
        SEL_HOUR10 = 7'b0000010,
        SEL_HOUR1  = 7'b0000100,
        SEL_MIN10  = 7'b0001000,
        SEL_MIN1   = 7'b0010000,
        SEL_SEC10  = 7'b0100000,
        SEL_SEC1   = 7'b1000000
    } digit_sel_e;

    localparam logic [1:0] RST_H10 = 2'(RST_HOUR / 10);
    localparam logic [3:0] RST_H1  = 4'(RST_HOUR % 10);
    localparam logic [2:0] RST_M10 = 3'(RST_MIN / 10);
    localparam logic [3:0] RST_M1  = 4'(RST_MIN % 10);
    localparam logic [2:0] RST_S10 = 3'(RST_SEC / 10);
    localparam logic [3:0] RST_S1  = 4'(RST_SEC % 10);

    // One step of a single digit. Going up, anything at or above vmax wraps
    // to 0, so an out-of-range digit behaves as if it were at its maximum.
    // Going down, 0 wraps to vmax and an out-of-range digit lands on vmax.
    function automatic logic [3:0] step_digit(input logic [3:0] v,
                                              input logic [3:0] vmax,
                                              input logic       up);
        if (up)
            return (v >= vmax) ? 4'd0 : v + 4'd1;
        else if (v == 4'd0 || v > vmax)
            return vmax;
        else
            return v - 4'd1;
    endfunction

    logic [1:0] h10_q, h10_d;
    logic [3:0] h1_q,  h1_d;
    logic [2:0] m10_q, m10_d;
    logic [3:0] m1_q,  m1_d;
    logic [2:0] s10_q, s10_d;
    logic [3:0] s1_q,  s1_d;
    logic       day_carry_q, day_carry_d;

    // Zero-extended copies so every digit goes through the same 4-bit step.
    logic [3:0] h10_ext, m10_ext, s10_ext;
    logic [3:0] h1_max;
    logic       btn_up, btn_dn;

    assign h10_ext = {2'b00, h10_q};
    assign m10_ext = {1'b0, m10_q};
    assign s10_ext = {1'b0, s10_q};

    // Hour units run to 3 only in the twenties.
    assign h1_max = (h10_q >= 2'd2) ? 4'd3 : 4'd9;

`ifdef TIME_SET_DOWN_EN
    assign btn_dn = tbus.BAP_BTN4;
`else
    assign btn_dn = 1'b0;
`endif
    assign btn_up = tbus.BAP_BTN3;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        h10_d       = h10_q;
        h1_d        = h1_q;
        m10_d       = m10_q;
        m1_d        = m1_q;
        s10_d       = s10_q;
        s1_d        = s1_q;
        day_carry_d = 1'b0;

        if (!tbus.SEL_MODE0) begin
            // Run mode: a tick ripples through the digits; each stage only
            // moves when every lower stage wrapped.
            if (tbus.EN_1HZ) begin
                s1_d = step_digit(s1_q, 4'd9, 1'b1);
                if (s1_q >= 4'd9) begin
                    s10_d = 3'(step_digit(s10_ext, 4'd5, 1'b1));
                    if (s10_ext >= 4'd5) begin
                        m1_d = step_digit(m1_q, 4'd9, 1'b1);
                        if (m1_q >= 4'd9) begin
                            m10_d = 3'(step_digit(m10_ext, 4'd5, 1'b1));
                            if (m10_ext >= 4'd5) begin
                                h1_d = step_digit(h1_q, h1_max, 1'b1);
                                if (h1_q >= h1_max) begin
                                    if (h10_q >= 2'd2) begin
                                        h10_d       = 2'd0;
                                        day_carry_d = 1'b1;
                                    end else begin
                                        h10_d = h10_q + 2'd1;
                                    end
                                end
                            end
                        end
                    end
                end
            end
        end else if (btn_up ^ btn_dn) begin
            // Set mode: exactly one button pressed; step only the selected
            // digit. Anything not one-hot falls to default and is ignored.
            case (tbus.CURRENT_STATE_TIME)
                SEL_HOUR10: begin
                    h10_d = 2'(step_digit(h10_ext, 4'd2, btn_up));
                    // Landing in the twenties must not leave an hour like 29.
                    if (h10_d == 2'd2 && h1_q > 4'd3)
                        h1_d = 4'd3;
                end
                SEL_HOUR1: h1_d  = step_digit(h1_q, h1_max, btn_up);
                SEL_MIN10: m10_d = 3'(step_digit(m10_ext, 4'd5, btn_up));
                SEL_MIN1:  m1_d  = step_digit(m1_q, 4'd9, btn_up);
                SEL_SEC10: s10_d = 3'(step_digit(s10_ext, 4'd5, btn_up));
                SEL_SEC1:  s1_d  = step_digit(s1_q, 4'd9, btn_up);
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            h10_q       <= RST_H10;
            h1_q        <= RST_H1;
            m10_q       <= RST_M10;
            m1_q        <= RST_M1;
            s10_q       <= RST_S10;
            s1_q        <= RST_S1;
            day_carry_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            h10_q       <= h10_d;
            h1_q        <= h1_d;
            m10_q       <= m10_d;
            m1_q        <= m1_d;
            s10_q       <= s10_d;
            s1_q        <= s1_d;
            day_carry_q <= day_carry_d;
        end
    end

    assign tbus.TIME_H10  = h10_q;
    assign tbus.TIME_H1   = h1_q;
    assign tbus.TIME_M10  = m10_q;
    assign tbus.TIME_M1   = m1_q;
    assign tbus.TIME_S10  = s10_q;
    assign tbus.TIME_S1   = s1_q;
    assign tbus.DAY_CARRY = day_carry_q;

endmodule
